// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes and the 1149.1 transition table.
package jtag_pkg;

   localparam int IR_W = 4;

   localparam logic [IR_W-1:0] INSTR_IDCODE = 4'b0001;
   localparam logic [IR_W-1:0] INSTR_USER   = 4'b1000;
   localparam logic [IR_W-1:0] INSTR_BYPASS = 4'b1111;

   typedef enum logic [3:0] {
      TLR        = 4'h0,
      RTI        = 4'h1,
      SELECT_DR  = 4'h2,
      CAPTURE_DR = 4'h3,
      SHIFT_DR   = 4'h4,
      EXIT1_DR   = 4'h5,
      PAUSE_DR   = 4'h6,
      EXIT2_DR   = 4'h7,
      UPDATE_DR  = 4'h8,
      SELECT_IR  = 4'h9,
      CAPTURE_IR = 4'hA,
      SHIFT_IR   = 4'hB,
      EXIT1_IR   = 4'hC,
      PAUSE_IR   = 4'hD,
      EXIT2_IR   = 4'hE,
      UPDATE_IR  = 4'hF
   } tap_state_t;

   function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
      tap_state_t n;
      case (s)
         TLR:        n = tms ? TLR       : RTI;
         RTI:        n = tms ? SELECT_DR : RTI;
         SELECT_DR:  n = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: n = tms ? EXIT1_DR  : SHIFT_DR;
         SHIFT_DR:   n = tms ? EXIT1_DR  : SHIFT_DR;
         EXIT1_DR:   n = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   n = tms ? EXIT2_DR  : PAUSE_DR;
         EXIT2_DR:   n = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  n = tms ? SELECT_DR : RTI;
         SELECT_IR:  n = tms ? TLR       : CAPTURE_IR;
         CAPTURE_IR: n = tms ? EXIT1_IR  : SHIFT_IR;
         SHIFT_IR:   n = tms ? EXIT1_IR  : SHIFT_IR;
         EXIT1_IR:   n = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   n = tms ? EXIT2_IR  : PAUSE_IR;
         EXIT2_IR:   n = tms ? UPDATE_IR : SHIFT_IR;
         default:    n = tms ? SELECT_DR : RTI;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_tap_oversampled_if.sv
// JTAG header pins plus the fabric-side USER debug channel of the oversampled TAP.
interface jtag_tap_oversampled_if #(
   parameter int USER_W = 32
);
   logic              tck;
   logic              tms;
   logic              tdi;
   logic              trst;
   logic              tdo;
   logic              tdo_oe;
   logic [USER_W-1:0] user_wdata;
   logic              user_wvalid;
   logic [USER_W-1:0] user_rdata;
   logic [3:0]        tap_state;

   modport master (
      output tck, tms, tdi, trst, user_rdata,
      input  tdo, tdo_oe, user_wdata, user_wvalid, tap_state
   );

   modport slave (
      input  tck, tms, tdi, trst, user_rdata,
      output tdo, tdo_oe, user_wdata, user_wvalid, tap_state
   );
endinterface

// File: rtl/jtag_pin_sync.sv
// Synchronises the four JTAG pins into clk and derives single-cycle tck edge pulses.
module jtag_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic tck,
   input  logic tms,
   input  logic tdi,
   input  logic trst,
   output logic tms_sync,
   output logic tdi_sync,
   output logic trst_sync,
   output logic tck_rise,
   output logic tck_fall
);
   // Bit order {trst, tdi, tms, tck}; trst resets to its inactive level.
   localparam logic [3:0] RST_VAL = 4'b1000;

   logic [3:0] pins;
   logic [3:0] synced;
   logic       tck_d_reg;

   assign pins = {trst, tdi, tms, tck};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_pin
         logic [SYNC_STAGES-1:0] chain_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) chain_reg <= {SYNC_STAGES{RST_VAL[gi]}};
            else     chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
         end
         assign synced[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tck_d_reg <= 1'b0;
      else     tck_d_reg <= synced[0];
   end

   assign tms_sync  = synced[1];
   assign tdi_sync  = synced[2];
   assign trst_sync = synced[3];
   assign tck_rise  = synced[0] & ~tck_d_reg;
   assign tck_fall  = ~synced[0] & tck_d_reg;
endmodule

// File: rtl/jtag_tap_oversampled.sv
// 1149.1 TAP controller running on the system clock with IDCODE, BYPASS and a USER debug register.
module jtag_tap_oversampled
   import jtag_pkg::*;
#(
   parameter logic [31:0] IDCODE_VAL  = 32'h1BA5_E001,
   parameter int          USER_W      = 32,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   jtag_tap_oversampled_if.slave bus
);
   logic tms_sync, tdi_sync, trst_sync, tck_rise, tck_fall;

   jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .tck       (bus.tck),
      .tms       (bus.tms),
      .tdi       (bus.tdi),
      .trst      (bus.trst),
      .tms_sync  (tms_sync),
      .tdi_sync  (tdi_sync),
      .trst_sync (trst_sync),
      .tck_rise  (tck_rise),
      .tck_fall  (tck_fall)
   );

   tap_state_t        state_reg;
   logic [IR_W-1:0]   ir_reg;
   logic [IR_W-1:0]   ir_sr_reg;
   logic [31:0]       id_sr_reg;
   logic [USER_W-1:0] user_sr_reg;
   logic              byp_reg;
   logic              tdo_reg;
   logic              tdo_oe_reg;
   logic [USER_W-1:0] user_wdata_reg;
   logic              user_wvalid_reg;
   logic              dr_lsb;

   // Undefined instruction codes fall through to the bypass bit.
   always_comb begin
      dr_lsb = byp_reg;
      if (ir_reg == INSTR_IDCODE)    dr_lsb = id_sr_reg[0];
      else if (ir_reg == INSTR_USER) dr_lsb = user_sr_reg[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= TLR;
         ir_reg          <= INSTR_IDCODE;
         ir_sr_reg       <= '0;
         id_sr_reg       <= '0;
         user_sr_reg     <= '0;
         byp_reg         <= 1'b0;
         tdo_reg         <= 1'b0;
         tdo_oe_reg      <= 1'b0;
         user_wdata_reg  <= '0;
         user_wvalid_reg <= 1'b0;
      end else begin
         user_wvalid_reg <= 1'b0;
         if (!trst_sync) begin
            state_reg  <= TLR;
            ir_reg     <= INSTR_IDCODE;
            tdo_reg    <= 1'b0;
            tdo_oe_reg <= 1'b0;
         end else if (tck_rise) begin
            state_reg <= tap_next(state_reg, tms_sync);
            case (state_reg)
               TLR:        ir_reg    <= INSTR_IDCODE;
               CAPTURE_IR: ir_sr_reg <= 4'b0001;
               SHIFT_IR:   ir_sr_reg <= {tdi_sync, ir_sr_reg[IR_W-1:1]};
               UPDATE_IR:  ir_reg    <= ir_sr_reg;
               CAPTURE_DR: begin
                  case (ir_reg)
                     INSTR_IDCODE: id_sr_reg   <= IDCODE_VAL;
                     INSTR_USER:   user_sr_reg <= bus.user_rdata;
                     default:      byp_reg     <= 1'b0;
                  endcase
               end
               SHIFT_DR: begin
                  case (ir_reg)
                     INSTR_IDCODE: id_sr_reg   <= {tdi_sync, id_sr_reg[31:1]};
                     INSTR_USER:   user_sr_reg <= {tdi_sync, user_sr_reg[USER_W-1:1]};
                     default:      byp_reg     <= tdi_sync;
                  endcase
               end
               UPDATE_DR: begin
                  if (ir_reg == INSTR_USER) begin
                     user_wdata_reg  <= user_sr_reg;
                     user_wvalid_reg <= 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (tck_fall) begin
            if (state_reg == SHIFT_IR) begin
               tdo_reg    <= ir_sr_reg[0];
               tdo_oe_reg <= 1'b1;
            end else if (state_reg == SHIFT_DR) begin
               tdo_reg    <= dr_lsb;
               tdo_oe_reg <= 1'b1;
            end else begin
               tdo_reg    <= 1'b0;
               tdo_oe_reg <= 1'b0;
            end
         end
      end
   end

   assign bus.tdo         = tdo_reg;
   assign bus.tdo_oe      = tdo_oe_reg;
   assign bus.user_wdata  = user_wdata_reg;
   assign bus.user_wvalid = user_wvalid_reg;
   assign bus.tap_state   = state_reg;
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for the oversampled TAP, ending with a random walk against a behavioural TAP model.
module tb_jtag_tap_oversampled;
   import jtag_pkg::*;

   localparam logic [31:0] IDCODE = 32'h1BA5_E001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   jtag_tap_oversampled_if #(.USER_W(32)) bus ();

   jtag_tap_oversampled #(
      .IDCODE_VAL  (IDCODE),
      .USER_W      (32),
      .SYNC_STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int wvalid_cnt = 0;

   always @(posedge clk) if (bus.user_wvalid) wvalid_cnt <= wvalid_cnt + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One tck period, 4 clk high / 4 clk low; returns tdo as seen just before the rising edge.
   task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
      t_do     = bus.tdo;
      bus.tms  = t_ms;
      bus.tdi  = t_di;
      bus.tck  = 1'b1;
      repeat (4) @(posedge clk);
      #1 bus.tck = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Shift n bits LSB first, leave via EXIT1 -> UPDATE -> RTI.
   task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      dout = '0;
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], b);
         dout[i] = b;
      end
      tck_cycle(1'b1, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
   endtask

   task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
      logic b;
      tck_cycle(1'b1, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      shift_bits(n, din, dout);
      $display("scan DR %0d bits in=%h out=%h", n, din, dout);
   endtask

   task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
      logic b;
      logic [31:0] d;
      tck_cycle(1'b1, 1'b0, b);
      tck_cycle(1'b1, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      shift_bits(4, {28'b0, din}, d);
      dout = d[3:0];
      $display("scan IR in=%b out=%b", din, dout);
   endtask

   // Behavioural reference TAP for the random walk.
   tap_state_t  m_state;
   logic [3:0]  m_ir, m_irsr;
   logic [31:0] m_dr, m_wdata;
   logic        m_byp, m_tdo;

   function automatic tap_state_t m_next(input tap_state_t s, input logic t);
      case (s)
         TLR:        return t ? TLR       : RTI;
         RTI:        return t ? SELECT_DR : RTI;
         SELECT_DR:  return t ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR: return t ? EXIT1_DR  : SHIFT_DR;
         SHIFT_DR:   return t ? EXIT1_DR  : SHIFT_DR;
         EXIT1_DR:   return t ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:   return t ? EXIT2_DR  : PAUSE_DR;
         EXIT2_DR:   return t ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:  return t ? SELECT_DR : RTI;
         SELECT_IR:  return t ? TLR       : CAPTURE_IR;
         CAPTURE_IR: return t ? EXIT1_IR  : SHIFT_IR;
         SHIFT_IR:   return t ? EXIT1_IR  : SHIFT_IR;
         EXIT1_IR:   return t ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:   return t ? EXIT2_IR  : PAUSE_IR;
         EXIT2_IR:   return t ? UPDATE_IR : SHIFT_IR;
         default:    return t ? SELECT_DR : RTI;
      endcase
   endfunction

   task automatic model_step(input logic t_ms, input logic t_di);
      logic user_sel;
      user_sel = (m_ir == 4'b0001) || (m_ir == 4'b1000);
      case (m_state)
         TLR:        m_ir   = 4'b0001;
         CAPTURE_IR: m_irsr = 4'b0001;
         SHIFT_IR:   m_irsr = {t_di, m_irsr[3:1]};
         UPDATE_IR:  m_ir   = m_irsr;
         CAPTURE_DR: begin
            if (m_ir == 4'b0001)      m_dr  = IDCODE;
            else if (m_ir == 4'b1000) m_dr  = bus.user_rdata;
            else                      m_byp = 1'b0;
         end
         SHIFT_DR: begin
            if (user_sel) m_dr  = {t_di, m_dr[31:1]};
            else          m_byp = t_di;
         end
         UPDATE_DR: if (m_ir == 4'b1000) m_wdata = m_dr;
         default: ;
      endcase
      m_state = m_next(m_state, t_ms);
      user_sel = (m_ir == 4'b0001) || (m_ir == 4'b1000);
      if (m_state == SHIFT_IR)      m_tdo = m_irsr[0];
      else if (m_state == SHIFT_DR) m_tdo = user_sel ? m_dr[0] : m_byp;
      else                          m_tdo = 1'b0;
   endtask

   logic [31:0] dout;
   logic [3:0]  iro;
   logic        b, t_ms, t_di, exp_tdo;
   int          cnt0;

   initial begin
      bus.tck = 1'b0;
      bus.tms = 1'b1;
      bus.tdi = 1'b0;
      bus.trst = 1'b1;
      bus.user_rdata = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // 1. reset values, then idle with tck parked
      check("rst_state",  {28'b0, bus.tap_state}, TLR);
      check("rst_tdo",    {31'b0, bus.tdo}, 0);
      check("rst_tdo_oe", {31'b0, bus.tdo_oe}, 0);
      check("rst_wdata",  bus.user_wdata, 0);
      check("rst_wvalid", {31'b0, bus.user_wvalid}, 0);
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("idle_state",  {28'b0, bus.tap_state}, TLR);
      check("idle_tdo_oe", {31'b0, bus.tdo_oe}, 0);

      // 2. IDCODE readout
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, b);
      check("tlr_hold", {28'b0, bus.tap_state}, TLR);
      tck_cycle(1'b0, 1'b0, b);
      check("to_rti", {28'b0, bus.tap_state}, RTI);
      scan_dr(32, 32'h0, dout);
      check("idcode", dout, 32'h1BA5_E001);
      check("back_rti", {28'b0, bus.tap_state}, RTI);

      // 3. BYPASS: one-bit delay
      scan_ir(4'b1111, iro);
      check("ir_capture", {28'b0, iro}, 4'b0001);
      scan_dr(4, 32'b1101, dout);
      check("bypass", dout, 32'b1010);

      // 4. USER write then readback
      bus.user_rdata = 32'h1234_5678;
      scan_ir(4'b1000, iro);
      cnt0 = wvalid_cnt;
      scan_dr(32, 32'hDEAD_BEEF, dout);
      check("user_cap1", dout, 32'h1234_5678);
      check("user_wdata1", bus.user_wdata, 32'hDEAD_BEEF);
      check("user_wvalid1", wvalid_cnt - cnt0, 1);
      bus.user_rdata = 32'h0000_00A5;
      cnt0 = wvalid_cnt;
      scan_dr(32, 32'hDEAD_BEEF, dout);
      check("user_cap2", dout, 32'h0000_00A5);
      check("user_wvalid2", wvalid_cnt - cnt0, 1);

      // 5. trst mid SHIFT_DR with IR=USER
      cnt0 = wvalid_cnt;
      tck_cycle(1'b1, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      tck_cycle(1'b0, 1'b0, b);
      for (int i = 0; i < 5; i++) tck_cycle(1'b0, 1'b1, b);
      check("mid_shift_state", {28'b0, bus.tap_state}, SHIFT_DR);
      check("mid_shift_oe", {31'b0, bus.tdo_oe}, 1);
      bus.trst = 1'b0;
      for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, b);
      check("trst_state", {28'b0, bus.tap_state}, TLR);
      check("trst_oe", {31'b0, bus.tdo_oe}, 0);
      check("trst_wdata", bus.user_wdata, 32'hDEAD_BEEF);
      bus.trst = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("trst_wvalid", wvalid_cnt - cnt0, 0);
      $display("trst pulse done state=%h", bus.tap_state);
      tck_cycle(1'b0, 1'b0, b);
      scan_dr(32, 32'h0, dout);
      check("trst_ir_idcode", dout, 32'h1BA5_E001);

      // 6a. undefined instruction acts as BYPASS
      cnt0 = wvalid_cnt;
      scan_ir(4'b0110, iro);
      scan_dr(4, 32'b1101, dout);
      check("undef_bypass", dout, 32'b1010);
      check("undef_no_write", wvalid_cnt - cnt0, 0);

      // 6b. random walk against the reference model
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.user_rdata = 32'hC3C3_5A5A;
      m_state = TLR; m_ir = 4'b0001; m_irsr = '0; m_dr = '0;
      m_wdata = '0;  m_byp = 1'b0;   m_tdo = 1'b0;
      for (int i = 0; i < 200; i++) begin
         t_ms = ($urandom_range(0, 2) == 0);
         t_di = 1'($urandom_range(0, 1));
         exp_tdo = m_tdo;
         tck_cycle(t_ms, t_di, b);
         model_step(t_ms, t_di);
         $display("rand %0d tms=%b tdi=%b state=%h tdo=%b", i, t_ms, t_di, bus.tap_state, b);
         check("rand_tdo",   {31'b0, b}, {31'b0, exp_tdo});
         check("rand_state", {28'b0, bus.tap_state}, {28'b0, m_state});
         check("rand_wdata", bus.user_wdata, m_wdata);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
